// File: rtl/dma.sv
// Single-channel memory-to-memory DMA engine: copies len words from a source
// to a destination pointer over one shared memory port (READ, WAIT, WRITE per word).
module dma (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] src_addr,
  input  logic [31:0] dest_addr,
  input  logic [31:0] len,
  output logic        busy,
  output logic        done,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write,
  output logic        mem_r_en,
  output logic        mem_w_en,
  input  logic [31:0] mem_read
);

  typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, DONE} state_t;

  state_t      state, state_next;
  logic [31:0] src_ptr, dst_ptr, len_reg, count, data_reg;
  logic [31:0] count_inc;

  assign count_inc = count + 32'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = (len == 32'd0) ? DONE : READ;
      READ:    state_next = WAIT;
      WAIT:    state_next = WRITE;
      WRITE:   state_next = (count_inc == len_reg) ? DONE : READ;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Transfer parameters are captured once at start; later input changes are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_ptr  <= 32'd0;
      dst_ptr  <= 32'd0;
      len_reg  <= 32'd0;
      count    <= 32'd0;
      data_reg <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            src_ptr <= src_addr;
            dst_ptr <= dest_addr;
            len_reg <= len;
            count   <= 32'd0;
          end
        end
        WAIT: data_reg <= mem_read;
        WRITE: begin
          src_ptr <= src_ptr + 32'd4;
          dst_ptr <= dst_ptr + 32'd4;
          count   <= count_inc;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    mem_r_en  = 1'b0;
    mem_w_en  = 1'b0;
    mem_addr  = 32'd0;
    mem_write = 32'd0;
    case (state)
      READ: begin
        busy     = 1'b1;
        mem_r_en = 1'b1;
        mem_addr = src_ptr;
      end
      WAIT: busy = 1'b1;
      WRITE: begin
        busy      = 1'b1;
        mem_w_en  = 1'b1;
        mem_addr  = dst_ptr;
        mem_write = data_reg;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dma.sv
// Self-checking bench for dma: table vectors, randomized transfers against a
// word-copy reference model, plus reset-abort and wrap-around sequences.
module tb_dma;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] src_addr, dest_addr, len;
  logic        busy, done, mem_r_en, mem_w_en;
  logic [31:0] mem_addr, mem_write;
  logic [31:0] mem_read = 32'd0;

  logic [31:0] mem      [256];
  logic [31:0] load_img [256];
  logic [31:0] ref_mem  [256];
  logic        load_req = 1'b0;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [32:0] got_seq[$];
  logic [32:0] exp_seq[$];

  typedef struct {
    logic [31:0] src;
    logic [31:0] dst;
    logic [31:0] len;
    int          exp_done;
    int          exp_busy;
    int          glitch;
  } vec_t;

  vec_t vecs[6];

  dma dut (
    .clk(clk), .rst(rst), .start(start),
    .src_addr(src_addr), .dest_addr(dest_addr), .len(len),
    .busy(busy), .done(done),
    .mem_addr(mem_addr), .mem_write(mem_write),
    .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .mem_read(mem_read)
  );

  always #5 clk = ~clk;

  // Word-wide memory with one-cycle registered read, indexed by address bits [9:2].
  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < 256; i++) mem[i] <= load_img[i];
    end else begin
      if (mem_w_en) mem[mem_addr[9:2]] <= mem_write;
      if (mem_r_en) mem_read <= mem[mem_addr[9:2]];
    end
  end

  function automatic int idx(logic [31:0] a);
    return int'(a[9:2]);
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic check_mem(input string name);
    int bad = 0;
    int first = -1;
    for (int i = 0; i < 256; i++)
      if (mem[i] !== ref_mem[i]) begin
        bad++;
        if (first < 0) first = i;
      end
    n_cmp++;
    if (bad != 0) begin
      n_fail++;
      $display("[TB] FAIL %s: %0d words differ, first word %0d got 0x%08h expected 0x%08h",
               name, bad, first, mem[first], ref_mem[first]);
    end
  endtask

  // Runs one transfer; glitch > 0 pulses start with different arguments in that cycle.
  task automatic apply_stimulus(input logic [31:0] src, input logic [31:0] dst, input logic [31:0] n,
                                input int glitch, input int exp_done, input int exp_busy, input string tag);
    int done_cycle = -1;
    int n_done = 0;
    int busy_cnt = 0;
    int overlap = 0;
    int both = 0;
    int tail = -1;
    int budget;
    logic seq_ok;

    exp_seq.delete();
    got_seq.delete();
    for (int i = 0; i < int'(n); i++) begin
      exp_seq.push_back({1'b0, src + 32'(4 * i)});
      exp_seq.push_back({1'b1, dst + 32'(4 * i)});
      ref_mem[idx(dst + 32'(4 * i))] = ref_mem[idx(src + 32'(4 * i))];
    end

    @(negedge clk);
    src_addr = src; dest_addr = dst; len = n; start = 1'b1;
    budget = 3 * int'(n) + 20;
    for (int c = 1; c <= budget && tail != 0; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start = 1'b0;
        src_addr = $urandom; dest_addr = $urandom; len = $urandom_range(1, 9);
      end
      if (busy) busy_cnt++;
      if (busy && done) overlap++;
      if (mem_r_en && mem_w_en) both++;
      if (mem_r_en) got_seq.push_back({1'b0, mem_addr});
      if (mem_w_en) got_seq.push_back({1'b1, mem_addr});
      if (done) begin
        n_done++;
        if (done_cycle < 0) begin
          done_cycle = c;
          tail = 5;
        end
      end
      if (tail > 0) tail--;
      if (glitch == c) begin
        start = 1'b1;
        src_addr = $urandom & 32'hFFFF_FFFC; dest_addr = $urandom & 32'hFFFF_FFFC; len = 32'd3;
      end else if (glitch == c - 1) begin
        start = 1'b0;
      end
    end

    seq_ok = (got_seq.size() == exp_seq.size());
    if (seq_ok)
      foreach (exp_seq[i]) if (got_seq[i] !== exp_seq[i]) seq_ok = 1'b0;

    check_output({tag, " done_cycle"}, 32'(done_cycle), 32'(exp_done));
    check_output({tag, " done_pulses"}, 32'(n_done), 32'd1);
    check_output({tag, " busy_cycles"}, 32'(busy_cnt), 32'(exp_busy));
    check_output({tag, " busy_done_overlap"}, 32'(overlap), 32'd0);
    check_output({tag, " both_strobes"}, 32'(both), 32'd0);
    check_output({tag, " addr_seq_ok"}, {31'd0, seq_ok}, 32'd1);
    if (!seq_ok) $display("[TB] %s: %0d strobes seen, %0d required", tag, got_seq.size(), exp_seq.size());
    check_mem({tag, " mem_image"});
  endtask

  task automatic reset_mid_transfer();
    int extra = 0;
    @(negedge clk);
    src_addr = 32'h0; dest_addr = 32'h40; len = 32'd4; start = 1'b1;
    ref_mem[idx(32'h40)] = ref_mem[idx(32'h0)];
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
    end
    check_output("abort busy_before", {31'd0, busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check_output("abort busy", {31'd0, busy}, 32'd0);
    check_output("abort done", {31'd0, done}, 32'd0);
    check_output("abort r_en", {31'd0, mem_r_en}, 32'd0);
    check_output("abort w_en", {31'd0, mem_w_en}, 32'd0);
    check_output("abort mem_addr", mem_addr, 32'd0);
    check_output("abort mem_write", mem_write, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (done || mem_r_en || mem_w_en || busy) extra++;
    end
    check_output("abort activity_after", 32'(extra), 32'd0);
    check_mem("abort mem_image");
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; src_addr = 32'd0; dest_addr = 32'd0; len = 32'd0;
    for (int i = 0; i < 256; i++) load_img[i] = $urandom;
    for (int i = 0; i < 4; i++) load_img[i] = 32'hA0A0_0000 + 32'(i);
    for (int i = 0; i < 256; i++) ref_mem[i] = load_img[i];

    #2 rst = 1'b1;
    #1;
    check_output("reset busy", {31'd0, busy}, 32'd0);
    check_output("reset done", {31'd0, done}, 32'd0);
    check_output("reset strobes", {30'd0, mem_r_en, mem_w_en}, 32'd0);
    check_output("reset mem_addr", mem_addr, 32'd0);
    check_output("reset mem_write", mem_write, 32'd0);
    @(negedge clk);
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    rst = 1'b0;

    vecs[0] = '{src: 32'h0,         dst: 32'h40,  len: 32'd4, exp_done: 13, exp_busy: 12, glitch: 0};
    vecs[1] = '{src: 32'h100,       dst: 32'h200, len: 32'd0, exp_done: 1,  exp_busy: 0,  glitch: 0};
    vecs[2] = '{src: 32'h20,        dst: 32'h60,  len: 32'd2, exp_done: 7,  exp_busy: 6,  glitch: 3};
    vecs[3] = '{src: 32'h30,        dst: 32'h70,  len: 32'd1, exp_done: 4,  exp_busy: 3,  glitch: 4};
    vecs[4] = '{src: 32'hFFFF_FFFC, dst: 32'h80,  len: 32'd2, exp_done: 7,  exp_busy: 6,  glitch: 0};
    vecs[5] = '{src: 32'h10,        dst: 32'h14,  len: 32'd3, exp_done: 10, exp_busy: 9,  glitch: 0};

    for (int v = 0; v < 6; v++) begin
      apply_stimulus(vecs[v].src, vecs[v].dst, vecs[v].len, vecs[v].glitch,
                     vecs[v].exp_done, vecs[v].exp_busy, $sformatf("vec%0d", v));
      if (v == 0) begin
        for (int i = 0; i < 4; i++)
          check_output($sformatf("basic dest_word%0d", i), mem[16 + i], 32'hA0A0_0000 + 32'(i));
      end
      if (v == 4 && got_seq.size() >= 3) begin
        check_output("wrap read0", got_seq[0][31:0], 32'hFFFF_FFFC);
        check_output("wrap read1", got_seq[2][31:0], 32'h0000_0000);
      end
    end

    reset_mid_transfer();

    for (int r = 0; r < 20; r++) begin
      logic [31:0] rs, rd, rl;
      rs = $urandom & 32'hFFFF_FFFC;
      rd = $urandom & 32'hFFFF_FFFC;
      rl = 32'($urandom_range(0, 10));
      apply_stimulus(rs, rd, rl, 0, 3 * int'(rl) + 1, 3 * int'(rl), $sformatf("rand%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dma.md
# dma

Single-channel memory-to-memory DMA engine. On a `start` pulse it copies `len` 32-bit words from a source byte address to a destination byte address over a single shared memory port with one-cycle synchronous read latency. It sits between a control master that programs and kicks transfers and a word-wide memory. It reports progress on `busy` and completion on a one-cycle `done` pulse.

## Interface
- No parameters. Data, address and length widths are fixed at 32 bits.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst` input 1: reset, asynchronous and active-high.
- `start` input 1: transfer request, sampled only in IDLE.
- `src_addr` input 32: source byte address, word aligned.
- `dest_addr` input 32: destination byte address, word aligned.
- `len` input 32: transfer length in 32-bit words, unsigned.
- `busy` output 1: high while a transfer is in progress (READ, WAIT and WRITE states).
- `done` output 1: one-cycle completion pulse.
- `mem_addr` output 32: memory byte address.
- `mem_write` output 32: memory write data.
- `mem_r_en` output 1: memory read strobe.
- `mem_w_en` output 1: memory write strobe.
- `mem_read` input 32: memory read data. It is registered in the memory and is valid in the cycle after the cycle with `mem_r_en` high.

## Operation
- FSM states: IDLE, READ, WAIT, WRITE, DONE. All outputs decode from the state and registers only; there are no combinational paths from inputs to outputs.
- **IDLE:**
  - If `start` is 1 at a clock edge: latch `src_addr` into the source pointer, `dest_addr` into the destination pointer and `len` into the length register; clear the word counter.
  - Then go to DONE if `len` == 0, otherwise go to READ.
- **READ:**
  - Drive `mem_r_en`=1 and `mem_addr`=source pointer.
  - Next state: WAIT.
- **WAIT:**
  - No strobes asserted.
  - Capture `mem_read` into the data register at the closing edge.
  - Next state: WRITE.
- **WRITE:**
  - Drive `mem_w_en`=1, `mem_addr`=destination pointer, `mem_write`=data register.
  - At the closing edge: source pointer += 4, destination pointer += 4, counter += 1.
  - Go to DONE if the new counter equals the length register, otherwise go to READ.
- **DONE:**
  - Drive `done`=1 for exactly one cycle.
  - Next state: IDLE.
- **Output values outside the active states:**
  - `mem_addr` and `mem_write` are 0 outside READ/WRITE, except that `mem_addr`=0 in WAIT.
  - `mem_r_en` and `mem_w_en` are never both high.
- **Arithmetic:**
  - Pointers increment modulo 2^32; address wrap-around is silent.
  - The counter is 32 bits unsigned.
  - Address bits [1:0] are passed through unchanged; the block performs no alignment check.
- **Boundary conditions:**
  - `start` in any state other than IDLE is ignored. This includes the DONE cycle.
  - `src_addr`, `dest_addr` and `len` changing after they are latched have no effect.
  - Overlapping source and destination regions are copied strictly in ascending word order: read word i, then write word i.

## Timing
- **Reset:**
  - Asynchronous assertion forces state IDLE immediately.
  - All outputs go to 0: `busy`, `done`, `mem_r_en`, `mem_w_en`, `mem_addr`, `mem_write`.
  - Pointers, counter and data register are cleared.
- **Reset mid-transfer:** aborts the transfer. No further strobes are issued, and `done` is not asserted for the aborted transfer.
- **Per word:** 3 cycles (READ, WAIT, WRITE).
- **Latency:** with `start` sampled at edge E0, READ for word 0 occupies cycle 1 and `done` is high in cycle 3·`len`+1.
- **Zero length:** `len`=0 gives `done` in cycle 1 with no memory strobes.
- **Back-to-back transfers:** the earliest next accepted `start` is at the edge ending the first IDLE cycle after DONE.

## Test plan
- **Basic copy:**
  - Setup: reset, then preload mem words 0..3 = 0xA0A00000..0xA0A00003.
  - Stimulus: `src_addr`=0x0, `dest_addr`=0x40, `len`=4, one-cycle `start`.
  - Required response: `done` pulses once, 13 cycles after the start edge. Words at 0x40..0x4C = 0xA0A00000..0xA0A00003, and source words are unchanged.
- **Strobe/address sequence:**
  - Stimulus: same transfer as the basic copy.
  - Required response: the `mem_addr` sequence is R0x0, W0x40, R0x4, W0x44, R0x8, W0x48, R0xC, W0x4C. `busy` is high for exactly 12 cycles, and `busy` and `done` are never high together.
- **Zero length:** `len`=0 with `start` -> `done` in cycle 1, `busy` never high, no `mem_r_en`/`mem_w_en`.
- **Start while busy:**
  - Stimulus: a second `start` with different addresses during a `len`=2 transfer.
  - Required response: ignored; only the first transfer is performed, and a single `done` pulse occurs.
- **Reset mid-transfer:**
  - Stimulus: assert `rst` asynchronously during the WAIT of word 1 of a `len`=4 transfer.
  - Required response: all outputs 0 immediately, only word 0 is copied, and no `done` pulse occurs.
- **Address wrap:**
  - Stimulus: `src_addr`=0xFFFFFFFC, `len`=2.
  - Required response: the read addresses are 0xFFFFFFFC then 0x00000000.
